// File: rtl/decode_stage_if.sv
// Fetch/execute-side bundle of the decode stage: instruction handshake in, decoded bundle handshake out.
`ifndef MemDoNothing
`define MemDoNothing 3'b011
`endif

interface decode_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic [31:0]     in_inst;
  logic            in_ready;
  logic            flush;
  logic            br_resolve;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      inst_opcode;
  logic [2:0]      inst_funct3;
  logic [6:0]      inst_funct7;
  logic [4:0]      inst_rd;
  logic [4:0]      inst_rs1;
  logic [4:0]      inst_rs2;
  logic            rd_wen;
  logic [XLEN-1:0] imm;
  logic            imm_valid;
  logic [2:0]      mem_opcode;
  logic            mem_unsigned;
  logic            mem_rdata_valid;
  logic            is_ctrl;
  logic            illegal;
  logic [CW-1:0]   fifo_count;

  modport master (
    output in_valid, in_inst, flush, br_resolve, out_ready,
    input  in_ready, out_valid, inst_opcode, inst_funct3, inst_funct7,
           inst_rd, inst_rs1, inst_rs2, rd_wen, imm, imm_valid, mem_opcode,
           mem_unsigned, mem_rdata_valid, is_ctrl, illegal, fifo_count
  );

  modport slave (
    input  in_valid, in_inst, flush, br_resolve, out_ready,
    output in_ready, out_valid, inst_opcode, inst_funct3, inst_funct7,
           inst_rd, inst_rs1, inst_rs2, rd_wen, imm, imm_valid, mem_opcode,
           mem_unsigned, mem_rdata_valid, is_ctrl, illegal, fifo_count
  );
endinterface

// File: rtl/decode_stage.sv
// RV32/RV64 decode stage: instruction FIFO, combinational decode of the head, registered
// valid/ready output bundle, issue hold after control transfers, synchronous flush.
module decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          br_wait;
  logic          push;
  logic          issue;
  logic [31:0]   head;

  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [20:0] imm_j;
  logic signed [31:0] imm_u;

  logic [XLEN-1:0] d_imm;
  logic            d_imm_valid;
  logic            d_rd_wen;
  logic [2:0]      d_mop;
  logic            d_mun;
  logic            d_mrv;
  logic            d_ctrl;
  logic            d_ill;

  assign head       = mem[rd_ptr];
  assign push       = bus.in_valid && bus.in_ready && !bus.flush;
  assign issue      = (count != '0) && !br_wait && (!bus.out_valid || bus.out_ready) && !bus.flush;
  assign count_next = count + CW'(push) - CW'(issue);
  assign bus.fifo_count = count;

  assign imm_i = head[31:20];
  assign imm_s = {head[31:25], head[11:7]};
  assign imm_b = {head[31], head[7], head[30:25], head[11:8], 1'b0};
  assign imm_j = {head[31], head[19:12], head[20], head[30:21], 1'b0};
  assign imm_u = {head[31:12], 12'b0};

  // Instruction storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_inst;
  end

  // in_ready is registered from next occupancy, so a pop never frees a slot in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      br_wait      <= 1'b0;
      bus.in_ready <= 1'b1;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (issue) rd_ptr <= rd_ptr + PW'(1);
      count        <= count_next;
      bus.in_ready <= (count_next != CW'(DEPTH));
      if (issue && d_ctrl) br_wait <= 1'b1;
      else if (bus.br_resolve) br_wait <= 1'b0;
    end
  end

  // Decode of the FIFO head.
  always_comb begin
    d_imm       = '0;
    d_imm_valid = 1'b1;
    d_rd_wen    = 1'b1;
    d_mop       = `MemDoNothing;
    d_mun       = 1'b0;
    d_mrv       = 1'b0;
    d_ctrl      = 1'b0;
    d_ill       = 1'b0;
    case (head[6:0])
      OP_STORE: begin
        d_imm    = XLEN'(imm_s);
        d_rd_wen = 1'b0;
        d_mop    = {1'b0, head[13:12]};
      end
      OP_LOAD: begin
        d_imm = XLEN'(imm_i);
        d_mop = {1'b1, head[13:12]};
        d_mun = head[14];
        d_mrv = 1'b1;
      end
      OP_BRANCH: begin
        d_imm    = XLEN'(imm_b);
        d_rd_wen = 1'b0;
        d_ctrl   = 1'b1;
      end
      OP_JAL: begin
        d_imm  = XLEN'(imm_j);
        d_ctrl = 1'b1;
      end
      OP_JALR: begin
        d_imm  = XLEN'(imm_i);
        d_ctrl = 1'b1;
      end
      OP_LUI, OP_AUIPC: d_imm = XLEN'(imm_u);
      OP_IMM: begin
        // funct3 001/101 are shifts: the immediate is the unsigned shift amount.
        if (head[13:12] == 2'b01) begin
          if (XLEN == 64) d_imm = XLEN'(head[25:20]);
          else            d_imm = XLEN'(head[24:20]);
        end else begin
          d_imm = XLEN'(imm_i);
        end
      end
      OP_ALU: d_imm_valid = 1'b0;
      default: begin
        d_rd_wen    = 1'b0;
        d_imm_valid = 1'b0;
        d_ill       = 1'b1;
      end
    endcase
  end

  // Output bundle register: loads on issue, holds while execute stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid       <= 1'b0;
      bus.inst_opcode     <= '0;
      bus.inst_funct3     <= '0;
      bus.inst_funct7     <= '0;
      bus.inst_rd         <= '0;
      bus.inst_rs1        <= '0;
      bus.inst_rs2        <= '0;
      bus.rd_wen          <= 1'b0;
      bus.imm             <= '0;
      bus.imm_valid       <= 1'b0;
      bus.mem_opcode      <= `MemDoNothing;
      bus.mem_unsigned    <= 1'b0;
      bus.mem_rdata_valid <= 1'b0;
      bus.is_ctrl         <= 1'b0;
      bus.illegal         <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (issue) begin
      bus.out_valid       <= 1'b1;
      bus.inst_opcode     <= head[6:0];
      bus.inst_funct3     <= head[14:12];
      bus.inst_funct7     <= head[31:25];
      bus.inst_rd         <= head[11:7];
      bus.inst_rs1        <= head[19:15];
      bus.inst_rs2        <= head[24:20];
      bus.rd_wen          <= d_rd_wen;
      bus.imm             <= d_imm;
      bus.imm_valid       <= d_imm_valid;
      bus.mem_opcode      <= d_mop;
      bus.mem_unsigned    <= d_mun;
      bus.mem_rdata_valid <= d_mrv;
      bus.is_ctrl         <= d_ctrl;
      bus.illegal         <= d_ill;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: XLEN=32 and XLEN=64 instances driven in lockstep, expected
// decodes queued on each accepted push and compared on each accepted output.
`ifndef MemDoNothing
`define MemDoNothing 3'b011
`endif

module tb_decode_stage;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [8:0]  flags;  // {rd_wen, imm_valid, mem_opcode, mem_unsigned, mem_rdata_valid, is_ctrl, illegal}
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32), .DEPTH(DEPTH)) b32 ();
  decode_stage_if #(.XLEN(64), .DEPTH(DEPTH)) b64 ();

  decode_stage #(.XLEN(32), .DEPTH(DEPTH)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  decode_stage #(.XLEN(64), .DEPTH(DEPTH)) dut64 (.clk(clk), .rst(rst), .bus(b64));

  assign b64.in_valid   = b32.in_valid;
  assign b64.in_inst    = b32.in_inst;
  assign b64.flush      = b32.flush;
  assign b64.br_resolve = b32.br_resolve;
  assign b64.out_ready  = b32.out_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
    logic [63:0] mask;
    logic [63:0] r;
    mask = (64'd1 << bits) - 64'd1;
    r = v & mask;
    if (r[bits-1]) r = r | ~mask;
    return r;
  endfunction

  function automatic exp_t model(input logic [31:0] i);
    exp_t e;
    logic rw, iv, mu, mr, ct, il;
    logic [2:0] mo;
    logic shift;
    e.inst = i; e.imm64 = '0;
    rw = 1'b1; iv = 1'b1; mo = `MemDoNothing; mu = 1'b0; mr = 1'b0; ct = 1'b0; il = 1'b0;
    shift = (i[6:0] == 7'h13) && (i[14:12] == 3'd1 || i[14:12] == 3'd5);
    case (i[6:0])
      7'h03: begin e.imm64 = sx(64'(i[31:20]), 12); mo = {1'b1, i[13:12]}; mu = i[14]; mr = 1'b1; end
      7'h23: begin e.imm64 = sx(64'({i[31:25], i[11:7]}), 12); rw = 1'b0; mo = {1'b0, i[13:12]}; end
      7'h63: begin e.imm64 = sx(64'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13); rw = 1'b0; ct = 1'b1; end
      7'h6F: begin e.imm64 = sx(64'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21); ct = 1'b1; end
      7'h67: begin e.imm64 = sx(64'(i[31:20]), 12); ct = 1'b1; end
      7'h37, 7'h17: e.imm64 = sx(64'({i[31:12], 12'h000}), 32);
      7'h13: e.imm64 = shift ? 64'(i[25:20]) : sx(64'(i[31:20]), 12);
      7'h33: iv = 1'b0;
      default: begin rw = 1'b0; iv = 1'b0; il = 1'b1; end
    endcase
    e.imm32 = shift ? 32'(i[24:20]) : e.imm64[31:0];
    e.flags = {rw, iv, mo, mu, mr, ct, il};
    return e;
  endfunction

  // Scoreboard: record accepted pushes, compare accepted outputs in order.
  always @(negedge clk) begin
    if (rst || b32.flush) begin
      sb.delete();
    end else begin
      if (b32.out_valid && b32.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_out", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("fields", {b32.inst_funct7, b32.inst_rs2, b32.inst_rs1, b32.inst_funct3,
                           b32.inst_rd, b32.inst_opcode}, mon_e.inst);
          check("imm32", b32.imm, mon_e.imm32);
          check("flags", {b32.rd_wen, b32.imm_valid, b32.mem_opcode, b32.mem_unsigned,
                          b32.mem_rdata_valid, b32.is_ctrl, b32.illegal}, mon_e.flags);
          check("valid64", b64.out_valid, 64'd1);
          check("imm64", b64.imm, mon_e.imm64);
        end
      end
      if (b32.in_valid && b32.in_ready) sb.push_back(model(b32.in_inst));
    end
  end

  task automatic cycle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [31:0] inst);
    int n;
    bit done;
    n = 0; done = 1'b0;
    b32.in_valid = 1'b1;
    b32.in_inst  = inst;
    while (!done) begin
      @(negedge clk);
      if (b32.in_ready) done = 1'b1;
      else if (++n > 50) begin
        check("push_timeout", 64'd0, 64'd1);
        b32.in_valid = 1'b0;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    b32.in_valid = 1'b0;
  endtask

  // Returns at the negedge where out_valid is seen (or the budget runs out).
  task automatic wait_out(input string tag, input int budget);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!b32.out_valid && n < budget);
    check({tag, "_wait"}, b32.out_valid, 64'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check({tag, "_drained"}, 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_count"}, b32.fifo_count, 64'd0);
    check({tag, "_in_ready"}, b32.in_ready, 64'd1);
    check({tag, "_out_valid"}, b32.out_valid, 64'd0);
  endtask

  logic [31:0] stream [12] = '{32'h123450B7, 32'hFFFFF0B7, 32'h0020A423, 32'h0080A183,
                               32'hFFF0C283, 32'h002081B3, 32'h00309093, 32'h4210D093,
                               32'hFFF0B093, 32'h0000000F, 32'h00001117, 32'h0020B823};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    b32.in_valid = 1'b0; b32.in_inst = '0; b32.flush = 1'b0;
    b32.br_resolve = 1'b0; b32.out_ready = 1'b1;
    cycle(2);
    @(negedge clk);
    check_cleared("reset");
    check("reset_mem_opcode", b32.mem_opcode, 64'(`MemDoNothing));
    check("reset_imm", b32.imm, 64'd0);
    check("reset_rd_wen", b32.rd_wen, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // First-transaction latency: pushed at edge N, valid after edge N+1.
    b32.in_valid = 1'b1; b32.in_inst = 32'h00500093;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    @(negedge clk);
    check("lat_n1_valid", b32.out_valid, 64'd0);
    check("lat_n1_count", b32.fifo_count, 64'd1);
    @(negedge clk);
    check("lat_n2_valid", b32.out_valid, 64'd1);
    check("addi_rd", b32.inst_rd, 64'd1);
    check("addi_rs1", b32.inst_rs1, 64'd0);
    check("addi_imm", b32.imm, 64'd5);
    check("addi_mem_opcode", b32.mem_opcode, 64'(`MemDoNothing));
    @(posedge clk); #1;

    // Mixed stream at full rate.
    foreach (stream[k]) push(stream[k]);
    drain("stream");

    // Branch holds issue until resolved, then the queued addis flow back-to-back.
    push(32'hFE000EE3);
    wait_out("beq", 6);
    check("beq_imm", b32.imm, 64'hFFFFFFFC);
    check("beq_is_ctrl", b32.is_ctrl, 64'd1);
    @(posedge clk); #1;
    push(32'h00100093); push(32'h00200093); push(32'h00300093);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("br_hold", b32.out_valid, 64'd0);
    end
    @(posedge clk); #1;
    b32.br_resolve = 1'b1;
    @(posedge clk); #1;
    b32.br_resolve = 1'b0;
    wait_out("resolved", 4);
    @(negedge clk); check("b2b_1", b32.out_valid, 64'd1);
    @(negedge clk); check("b2b_2", b32.out_valid, 64'd1);
    @(posedge clk); #1;
    drain("branch");

    // Resolve coinciding with a new control issue: the new one keeps the hold.
    b32.br_resolve = 1'b1;
    push(32'h008000EF);
    push(32'h00700093);
    b32.br_resolve = 1'b0;
    @(negedge clk);
    check("jal_valid", b32.out_valid, 64'd1);
    check("jal_is_ctrl", b32.is_ctrl, 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("jal_hold", b32.out_valid, 64'd0);
    end
    @(posedge clk); #1;
    b32.br_resolve = 1'b1;
    @(posedge clk); #1;
    b32.br_resolve = 1'b0;
    wait_out("jal_resolved", 4);
    @(posedge clk); #1;
    drain("jal");

    // Stall: fill output register plus FIFO, then release across pointer wrap.
    b32.out_ready = 1'b0;
    for (int k = 0; k <= DEPTH; k++) push({12'(k + 10), 5'd0, 3'd0, 5'd1, 7'h13});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("full_count", b32.fifo_count, 64'(DEPTH));
      check("full_in_ready", b32.in_ready, 64'd0);
      check("stall_imm", b32.imm, 64'd10);
    end
    @(posedge clk); #1;
    b32.out_ready = 1'b1;
    b32.in_valid = 1'b1; b32.in_inst = 32'h01F00093;
    @(posedge clk); #1;
    @(negedge clk);
    check("no_bypass_count", b32.fifo_count, 64'(DEPTH - 1));
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    drain("stall");

    // Flush with full FIFO and a pending branch.
    push(32'hFE000EE3);
    wait_out("flush_beq", 6);
    @(posedge clk); #1;
    for (int k = 0; k < DEPTH; k++) push({12'(k + 40), 5'd0, 3'd0, 5'd2, 7'h13});
    @(negedge clk);
    check("pre_flush_count", b32.fifo_count, 64'(DEPTH));
    @(posedge clk); #1;
    b32.flush = 1'b1; b32.in_valid = 1'b1; b32.in_inst = 32'h06300093; b32.br_resolve = 1'b1;
    @(posedge clk); #1;
    b32.flush = 1'b0; b32.in_valid = 1'b0; b32.br_resolve = 1'b0;
    @(negedge clk);
    check_cleared("flush");
    @(posedge clk); #1;
    push(32'h00900093);
    wait_out("post_flush", 6);
    @(posedge clk); #1;
    drain("flush");

    // Reset mid-stream with a pending branch.
    push(32'hFE000EE3);
    wait_out("rst_beq", 6);
    @(posedge clk); #1;
    push(32'h00A00093); push(32'h00B00093);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_cleared("mid_reset");
    check("mid_reset_mem_opcode", b32.mem_opcode, 64'(`MemDoNothing));
    @(posedge clk); #1;
    rst = 1'b0;
    push(32'h00C00093);
    wait_out("post_reset", 6);
    @(posedge clk); #1;
    drain("reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, parametrised RV32/RV64 instruction-decode pipeline stage between fetch and execute. It buffers fetched instructions in an internal FIFO and decodes them into fields, immediate, register write-enable and memory opcode. It presents results through a valid/ready output register. It holds issue after a control-transfer instruction until execute resolves it, and supports a synchronous flush.

Parameters:
XLEN, 32, datapath width; 32 or 64; immediate is sign-extended to XLEN.
DEPTH, 4, instruction FIFO entries; power of two, >= 2.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  fetch offers inst
in_inst  in  32  raw instruction
in_ready  out  1  FIFO not full
flush  in  1  discard all buffered/issued state
br_resolve  in  1  execute resolved the outstanding control transfer
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
inst_opcode/inst_funct3/inst_funct7  out  7/3/7  instruction fields
inst_rd/inst_rs1/inst_rs2  out  5/5/5  register indices
rd_wen  out  1  instruction writes rd
imm  out  XLEN  decoded immediate, signed
imm_valid  out  1  imm is an operand (0 for R-type ALU)
mem_opcode  out  3  {is_load, funct3[1:0]}; `MemDoNothing for non-memory
mem_unsigned  out  1  funct3[2] for loads (LBU/LHU/LWU), else 0
mem_rdata_valid  out  1  load result comes from memory
is_ctrl  out  1  BRANCH, JAL or JALR
illegal  out  1  unrecognised opcode
fifo_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset: FIFO empty, fifo_count=0, in_ready=1, out_valid=0, br_wait=0. All bundle outputs 0, except mem_opcode=`MemDoNothing.
- Push when in_valid && in_ready. in_ready = (count != DEPTH). There is no bypass: when full, a simultaneous pop does not admit a push that cycle. Pointers wrap modulo DEPTH.
- Issue condition: FIFO non-empty && !br_wait && (!out_valid || out_ready). On issue, the head is popped and decoded into the output register, and out_valid is set.
- If out_valid && out_ready and there is no issue, out_valid clears. If !out_ready, the output register holds all values stable.
- Latency: inst pushed at edge N is first visible in FIFO cycle N+1; earliest out_valid is cycle N+2. Sustained throughput is 1/cycle.
- Issuing an instruction with is_ctrl=1 sets br_wait. br_wait blocks further issue and clears on br_resolve.
- br_resolve in the same cycle as a ctrl issue: the new ctrl wins and br_wait stays 1.
- flush (priority over everything except rst): empties the FIFO and clears out_valid and br_wait. in_valid and br_resolve are ignored that cycle. in_ready is 1 the next cycle.
- Decode (combinational on FIFO head, captured at issue):
  - Defaults: imm=0, imm_valid=1, rd_wen=1, mem_opcode=`MemDoNothing, mem_rdata_valid=0, is_ctrl=0, illegal=0.
  - STORE: S-imm sext; rd_wen=0; mem_opcode={0,funct3[1:0]}.
  - LOAD: I-imm sext; mem_opcode={1,funct3[1:0]}; mem_unsigned=funct3[2]; mem_rdata_valid=1.
  - BRANCH: B-imm sext (bit0=0); rd_wen=0; is_ctrl=1.
  - JAL: J-imm sext; is_ctrl=1.
  - JALR: I-imm sext; is_ctrl=1.
  - LUI/AUIPC: imm = sext({inst[31:12],12'b0}).
  - ALU_IMM: I-imm sext. For SLL/SRx, imm = zero-extended shamt: inst[24:20] when XLEN=32, inst[25:20] when XLEN=64. SLTIU uses sign-extended imm per ISA.
  - ALU: imm_valid=0.
  - Other opcodes: rd_wen=0, imm_valid=0, illegal=1. Still issued; no br_wait.
- Field outputs are raw slices of the issued instruction.

Test Plan:
- Push 0x00500093 (addi x1,x0,5) after reset -> out_valid in cycle 2; rd=1, rs1=0, imm=5, rd_wen=1, imm_valid=1, mem_opcode=`MemDoNothing.
- Push 0x123450B7 (lui x1) -> imm=0x12345000, rd_wen=1. With XLEN=64 -> imm=0x0000000012345000; 0xFFFFF0B7 -> 0xFFFFFFFFFFFFF000.
- Push 0x0020A423 (sw x2,8(x1)) then lw -> sw: imm=8, rd_wen=0, mem_opcode=3'b010; lw: mem_opcode=3'b110, mem_rdata_valid=1.
- Push 0xFE000EE3 (beq -4) then 3 addi -> imm=0xFFFFFFFC, is_ctrl=1. No further out_valid until br_resolve pulse; addi then issue back-to-back.
- Hold out_ready=0 and push DEPTH+2 insts -> in_ready=0 once fifo_count=DEPTH, output stable. Release -> all delivered in order, with no loss or duplication across pointer wrap.
- Full FIFO plus br_wait, assert flush -> next cycle fifo_count=0, out_valid=0, in_ready=1; the next pushed inst issues without br_resolve. Assert rst mid-stream -> identical cleared state.
